// File: rtl/button_conditioner.sv
// Synchronises and debounces the pause and direction push-buttons, producing one-cycle
// press strobes and the toggled pause / up_down levels that steer the display counter.

module ButtonDebouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic accept_o,
  output logic pulse_o
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  // The counter only ever has to reach DEBOUNCE_CYCLES-1 before the state changes.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           sync_q;
  logic                 stable;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_q;
  logic                 accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign stable = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= accept;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (stable) begin
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!stable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        cnt_d = '0;
        if (!stable) begin
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to high means the button is still held; no new press.
        if (stable) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign accept_o = accept;
  assign pulse_o  = pulse_q;

endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause,
  input  logic btn_dir,
  output logic pause_pulse,
  output logic dir_pulse,
  output logic pause,
  output logic up_down
);

  logic pauseAccept, dirAccept;
  logic pause_q, pause_d;
  logic upDown_q, upDown_d;

  ButtonDebouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_pauseDebounce (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (btn_pause),
    .accept_o(pauseAccept),
    .pulse_o (pause_pulse)
  );

  ButtonDebouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_dirDebounce (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (btn_dir),
    .accept_o(dirAccept),
    .pulse_o (dir_pulse)
  );

  // Levels flip on the same edge that launches the strobe, so both change together.
  always_comb begin
    pause_d  = pause_q ^ pauseAccept;
    upDown_d = upDown_q ^ dirAccept;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pause_q  <= 1'b0;
      upDown_q <= 1'b1;
    end else begin
      pause_q  <= pause_d;
      upDown_q <= upDown_d;
    end
  end

  assign pause   = pause_q;
  assign up_down = upDown_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model predicts strobes,
// a monitor pops predictions whenever the DUT strobes, and levels are compared every cycle.

module tb_button_conditioner;

  localparam int DEB = 4;

  typedef struct {
    int   cycle;
    logic pp;
    logic dp;
  } pulseExp_t;

  logic clk;
  logic reset;
  logic btnPause;
  logic btnDir;
  logic pausePulse;
  logic dirPulse;
  logic pauseLvl;
  logic upDown;

  pulseExp_t sbq[$];

  int   totalChecks = 0;
  int   passChecks  = 0;
  int   edgeCount   = 0;
  int   pausePulses = 0;
  int   dirPulses   = 0;
  int   lastPauseCycle = -1;
  int   lastDirCycle   = -1;

  logic [1:0] hist[2];
  int         runLen[2];
  logic       lastSamp[2];
  logic       debLevel[2];
  logic       expPause;
  logic       expUpDown;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_pause  (btnPause),
    .btn_dir    (btnDir),
    .pause_pulse(pausePulse),
    .dir_pulse  (dirPulse),
    .pause      (pauseLvl),
    .up_down    (upDown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual == expected) begin
      passChecks++;
    end else begin
      $display("[TB] FAIL %s: actual %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  // Inputs change only on falling edges and are held for n rising edges.
  task automatic applyStimulus(input logic bp, input logic bd, input int n);
    btnPause = bp;
    btnDir   = bd;
    repeat (n) @(negedge clk);
  endtask

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      hist[i]     = 2'b00;
      runLen[i]   = 0;
      lastSamp[i] = 1'b0;
      debLevel[i] = 1'b0;
    end
    expPause  = 1'b0;
    expUpDown = 1'b1;
    sbq.delete();
  endtask

  // A button's accepted level changes once the synchronised input has shown the new
  // value on DEB+1 consecutive edges; a change to 1 is a press.
  task automatic modelButton(input int b, input logic raw, output logic accepted);
    logic samp;
    samp    = hist[b][1];
    hist[b] = {hist[b][0], raw};
    accepted = 1'b0;
    if (samp == lastSamp[b]) runLen[b]++;
    else runLen[b] = 1;
    lastSamp[b] = samp;
    if (samp != debLevel[b] && runLen[b] >= DEB + 1) begin
      debLevel[b] = samp;
      accepted    = samp;
    end
  endtask

  initial begin
    logic pa, da;
    pulseExp_t e;
    resetModel();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        resetModel();
      end else begin
        edgeCount++;
        modelButton(0, btnPause, pa);
        modelButton(1, btnDir, da);
        if (pa) expPause = !expPause;
        if (da) expUpDown = !expUpDown;
        if (pa || da) begin
          e.cycle = edgeCount;
          e.pp    = pa;
          e.dp    = da;
          sbq.push_back(e);
        end
      end
    end
  end

  initial begin
    pulseExp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("pause_level", int'(pauseLvl), int'(expPause));
        checkOutput("up_down_level", int'(upDown), int'(expUpDown));
        while (sbq.size() > 0 && sbq[0].cycle < edgeCount) begin
          totalChecks++;
          $display("[TB] FAIL missed_pulse: actual none, expected strobe at edge %0d", sbq[0].cycle);
          void'(sbq.pop_front());
        end
        if (pausePulse || dirPulse) begin
          if (pausePulse) begin
            pausePulses++;
            lastPauseCycle = edgeCount;
          end
          if (dirPulse) begin
            dirPulses++;
            lastDirCycle = edgeCount;
          end
          if (sbq.size() == 0) begin
            totalChecks++;
            $display("[TB] FAIL unexpected_pulse: actual pause_pulse=%0d dir_pulse=%0d at edge %0d, expected none",
                     pausePulse, dirPulse, edgeCount);
          end else begin
            e = sbq.pop_front();
            checkOutput("pulse_cycle", edgeCount, e.cycle);
            checkOutput("pause_pulse", int'(pausePulse), int'(e.pp));
            checkOutput("dir_pulse", int'(dirPulse), int'(e.dp));
          end
        end
      end
    end
  end

  initial begin
    int startEdge;
    int p0;
    int remP;
    int remD;
    logic pat[9];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    reset    = 1'b0;
    btnPause = 1'b0;
    btnDir   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_pause", int'(pauseLvl), 0);
    checkOutput("reset_up_down", int'(upDown), 1);
    checkOutput("reset_pause_pulse", int'(pausePulse), 0);
    checkOutput("reset_dir_pulse", int'(dirPulse), 0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("idle_pause_pulses", pausePulses, 0);
    checkOutput("idle_dir_pulses", dirPulses, 0);
    checkOutput("idle_pause", int'(pauseLvl), 0);
    checkOutput("idle_up_down", int'(upDown), 1);

    $display("[TB] held pause press");
    startEdge = edgeCount + 1;
    applyStimulus(1'b1, 1'b0, 50);
    checkOutput("held_pause_count", pausePulses, 1);
    checkOutput("held_pause_latency", lastPauseCycle, startEdge + DEB + 2);
    checkOutput("held_pause_level", int'(pauseLvl), 1);
    applyStimulus(1'b0, 1'b0, 12);

    $display("[TB] bouncy direction input");
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, pat[i], 1);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("bounce_dir_count", dirPulses, 0);
    checkOutput("bounce_up_down", int'(upDown), 1);

    $display("[TB] two direction presses");
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("dir_first_count", dirPulses, 1);
    checkOutput("dir_first_up_down", int'(upDown), 0);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b0, 1'b1, 10);
    checkOutput("dir_second_count", dirPulses, 2);
    checkOutput("dir_second_up_down", int'(upDown), 1);
    applyStimulus(1'b0, 1'b0, 12);

    $display("[TB] asynchronous reset with pause held");
    btnPause = 1'b1;
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_pause", int'(pauseLvl), 0);
    checkOutput("async_reset_up_down", int'(upDown), 1);
    checkOutput("async_reset_pause_pulse", int'(pausePulse), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    startEdge = edgeCount + 1;
    p0 = pausePulses;
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("post_reset_count", pausePulses, p0 + 1);
    checkOutput("post_reset_latency", lastPauseCycle, startEdge + DEB + 2);
    checkOutput("post_reset_pause", int'(pauseLvl), 1);

    $display("[TB] release glitches while held");
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("glitch_count", pausePulses, p0 + 1);
    checkOutput("glitch_pause", int'(pauseLvl), 1);
    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("repress_count", pausePulses, p0 + 2);
    checkOutput("repress_pause", int'(pauseLvl), 0);
    applyStimulus(1'b0, 1'b0, 12);

    $display("[TB] simultaneous presses");
    startEdge = edgeCount + 1;
    applyStimulus(1'b1, 1'b1, 10);
    checkOutput("simul_pause_cycle", lastPauseCycle, startEdge + DEB + 2);
    checkOutput("simul_dir_cycle", lastDirCycle, startEdge + DEB + 2);
    checkOutput("simul_pause", int'(pauseLvl), 1);
    checkOutput("simul_up_down", int'(upDown), 0);
    applyStimulus(1'b0, 1'b0, 12);

    $display("[TB] randomized bursts");
    remP = 0;
    remD = 0;
    for (int c = 0; c < 3000; c++) begin
      if (remP == 0) begin
        btnPause = 1'($urandom_range(0, 1));
        remP     = int'($urandom_range(1, 9));
      end
      if (remD == 0) begin
        btnDir = 1'($urandom_range(0, 1));
        remD   = int'($urandom_range(1, 9));
      end
      remP--;
      remD--;
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0, 15);
    checkOutput("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end for the up/down display counter: takes two raw mechanical push-buttons (pause and direction), synchronises and debounces them, and produces clean one-cycle press pulses.
- Holds toggled level outputs `pause` and `up_down`, which drive the counter's control inputs directly.
- Runs on the fast board clock, not the divided slow clock, so presses are never missed between slow ticks.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a press or release (20 ms at 50 MHz).
- CNT_WIDTH, 20, width of each debounce counter; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1, board clock.
- reset, input, 1, asynchronous active-low reset.
- btn_pause, input, 1, raw pause button, active-high, asynchronous to clk, bouncy.
- btn_dir, input, 1, raw direction button, active-high, asynchronous to clk, bouncy.
- pause_pulse, output, 1, one-cycle strobe on each accepted pause press.
- dir_pulse, output, 1, one-cycle strobe on each accepted direction press.
- pause, output, 1, level: 1 = counter frozen; toggles on each pause_pulse.
- up_down, output, 1, level: 1 = count up, 0 = count down; toggles on each dir_pulse.

Behaviour:
- Reset: clk and reset are the only clock and reset. All registers are cleared asynchronously while reset == 0:
  - sync flops = 0, debounce counters = 0, both FSMs in IDLE.
  - pause = 0, up_down = 1, pause_pulse = 0, dir_pulse = 0.
- Synchronisation: each raw button passes through a 2-flop synchroniser. Only the second flop (s) feeds the logic.
- Per-button FSM: two identical, independent instances, one per button. Each has a CNT_WIDTH counter.
  - IDLE: counter = 0. If s = 1, go to PRESS_WAIT.
  - PRESS_WAIT: if s = 0, go to IDLE and clear the counter (bounce rejected, no pulse). Else increment the counter. When the counter reaches DEBOUNCE_CYCLES, go to PRESSED, clear the counter, and assert the pulse for exactly the next cycle.
  - PRESSED: if s = 0, go to RELEASE_WAIT. No further pulses while held, however long.
  - RELEASE_WAIT: if s = 1, go to PRESSED and clear the counter. Else increment. When the counter reaches DEBOUNCE_CYCLES, go to IDLE and clear the counter. Releases never pulse.
- Latency: if raw input is first sampled high at edge N and stays high, the pulse is high exactly during the cycle after edge N + DEBOUNCE_CYCLES + 2, for one cycle.
- Level outputs:
  - pause toggles in the same cycle that pause_pulse is high, and holds otherwise.
  - up_down toggles in the same cycle that dir_pulse is high, and holds otherwise.
  - Both are registered; no combinational path from any input.
- Simultaneous presses: both FSMs run independently. Both pulses may assert in the same cycle and both levels toggle.
- Minimum re-press interval: a second pulse needs a full debounced release (DEBOUNCE_CYCLES) plus a full debounced press.
- Reset mid-operation:
  - FSM returns to IDLE and levels return to pause = 0, up_down = 1.
  - A button still held when reset deasserts is treated as a fresh press and pulses after the normal latency.
- Counter width: counters saturate logically via the state transition. They must never wrap within a state.

Test Plan:
(Bench uses DEBOUNCE_CYCLES = 4, CNT_WIDTH = 3.)
- Reset then idle 20 cycles -> pause = 0, up_down = 1, no pulses; assert reset mid-run -> outputs return to these values immediately, without waiting for a clk edge.
- btn_pause high and held 50 cycles, first sampled at edge N -> pause_pulse high only in the cycle after edge N+6; pause goes 0 -> 1 in that cycle; no further pulse while held.
- btn_dir pattern 1,0,1,1,0,1,1,1,0 (one value per cycle, bounce shorter than 4 stable cycles), then low -> no dir_pulse, up_down stays 1.
- btn_dir press 10 cycles, release 10 cycles, press 10 cycles -> exactly two dir_pulse strobes; up_down sequence 1 -> 0 -> 1.
- Held btn_pause with release glitches of 1-2 cycles -> no second pulse; after a clean release of 10 cycles and a new press -> second pulse, pause returns to 0.
- btn_pause and btn_dir raised on the same edge -> pause_pulse and dir_pulse high in the same cycle; pause = 1 and up_down = 0 afterwards.
